imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Program loader that writes instruction words into the instruction memory's write port from a byte stream (host/UART side) before the core runs. Holds the processor in reset while loading. Assembles little-endian 32-bit words, writes them at word-aligned byte addresses, then pads the rest of memory with NOP (0x00000003). Sits between the boot byte source and the instruction memory; drives the core's hold input.

Parameters:
mem_size, 6, number of instruction words in the target memory (1..255)
nop_word, 32'h00000003, fill value for unloaded words

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load session
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  memory write strobe, one cycle per word
wr_addr  output  32  byte address of write, always word-aligned
wr_data  output  32  word to write
cpu_hold  output  1  holds processor in reset while high
done  output  1  load complete; level until next start
error  output  1  load failed; level until next start

Behaviour:
- One clock; reset asynchronous, active-high. Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, state=IDLE, counters=0.
- Byte handshake: transfer occurs on a rising edge where byte_valid && byte_ready. byte_ready is 1 only in COUNT, DATA, CHECK. Gaps in byte_valid are allowed at any point; no timeout.
- States: IDLE, COUNT, DATA, CHECK (macro only), FILL, DONE, ERROR.
- IDLE: waits for start -> COUNT; cpu_hold stays 1.
- start in DONE or ERROR: clears done/error, sets cpu_hold=1, -> COUNT. start in COUNT/DATA/CHECK/FILL ignored.
- COUNT: first accepted byte is word count N. N==0 or N>mem_size -> ERROR. Otherwise -> DATA with word_idx=0, byte_idx=0.
- DATA: byte k of a word (k=0..3) lands in bits [8k+7:8k]. On the edge accepting byte 3: wr_en=1 for exactly the next cycle, wr_addr=word_idx*4, wr_data=assembled word; word_idx increments. After word N-1: -> FILL (-> CHECK with macro).
- FILL: byte_ready=0; one registered write per cycle of nop_word at word_idx*4, consecutive cycles, word_idx = N..mem_size-1, starting the cycle after the last data write. If N==mem_size no fill writes. After last write -> DONE.
- DONE: done=1, cpu_hold=0, wr_en=0.
- ERROR: error=1, cpu_hold=1, wr_en=0, byte_ready=0. Words already written are not reverted.
- wr_en is never high two cycles apart from the defined schedule; wr_addr/wr_data hold last values when wr_en=0.
- Reset mid-session: all outputs return to reset values immediately (asynchronous); memory contents undefined; no further writes until next start.
- Widths: word_idx wide enough for mem_size; wr_addr zero-extended to 32 bits, bits [1:0] always 0.

Optional Feature:
LOADER_CHECKSUM_EN: when defined, after the last data byte the loader enters CHECK and accepts one extra byte. It compares this byte with the running XOR of all 4N data bytes: match -> FILL; mismatch -> ERROR (no fill writes). Without the macro, CHECK does not exist and DATA goes directly to FILL; the stream carries no checksum byte.

Test Plan:
- Reset asserted -> cpu_hold=1, wr_en=0, byte_ready=0, done=0, error=0; start pulse -> byte_ready=1 next cycle.
- N=2, bytes 13 05 50 00 93 05 A0 00 -> writes (0x0,0x00500513), (0x4,0x00A00593), then NOP at 0x8,0xC,0x10,0x14 on consecutive cycles; done=1, cpu_hold=0.
- N=6, bytes with random byte_valid gaps -> six data writes at 0x0..0x14, zero fill writes, done=1; word contents independent of gap pattern.
- N=0, then restart with N=7 -> error=1 each time, no wr_en pulse, cpu_hold=1; third start with N=1 succeeds.
- rst raised after 5 data bytes of N=2 -> all outputs at reset values asynchronously; no wr_en after release without a new start.
- With LOADER_CHECKSUM_EN, N=1, word 13 05 50 00, checksum 0x46 -> write, fill, done. Checksum 0x47 -> data write occurs, no fill, error=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream into instruction memory,
// pads the remainder with nop_word, and holds the core in reset until finished.
// Optional build macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte after the data).
module imem_loader #(
  parameter int          mem_size = 6,
  parameter logic [31:0] nop_word = 32'h00000003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int             IW    = $clog2(mem_size + 1);
  localparam logic [7:0]     MEM8  = 8'(mem_size);
  localparam logic [IW-1:0]  MEMI  = IW'(mem_size);
  localparam logic [IW-1:0]  LASTI = IW'(mem_size - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_FILL  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] word_cnt;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;
  logic          accept;
  logic          restart;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready; the source
  // may drop byte_valid at any time, and byte_ready depends only on the state register.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart    = 1'b1;
          state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_data == 8'd0 || byte_data > MEM8) state_next = S_ERROR;
          else                                      state_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3 && word_idx == word_cnt - IW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_FILL;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = (byte_data == csum) ? S_FILL : S_ERROR;
      end
`endif
      S_FILL: begin
        // The last pad write is issued on the same edge that enters DONE.
        if (word_idx >= LASTI) state_next = S_DONE;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          restart    = 1'b1;
          state_next = S_COUNT;
        end
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) begin
          restart    = 1'b1;
          state_next = S_COUNT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      word_cnt <= '0;
      word_idx <= '0;
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        word_idx <= '0;
        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end
      case (state)
        S_COUNT: begin
          if (accept) begin
            word_cnt <= byte_data[IW-1:0];
            word_idx <= '0;
            byte_idx <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= 32'({word_idx, 2'b00});
              wr_data  <= {byte_data, asm_q};
              word_idx <= word_idx + IW'(1);
            end else begin
              // Shift right so byte 0 ends up in the low lane after three bytes.
              asm_q <= {byte_data, asm_q[23:8]};
            end
          end
        end
        S_FILL: begin
          if (word_idx < MEMI) begin
            wr_en    <= 1'b1;
            wr_addr  <= 32'({word_idx, 2'b00});
            wr_data  <= nop_word;
            word_idx <= word_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a word-level
// reference model of the expected memory write sequence.
module tb_imem_loader;

  localparam int          MEM = 6;
  localparam logic [31:0] NOP = 32'h00000003;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int wr_count = 0;

  logic [63:0] exp_q[$];
  int          wr_cycles[$];
  logic [7:0]  data_b[$];

  imem_loader #(.mem_size(MEM), .nop_word(NOP)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // scoreboard: every write must match the head of the expected queue
  always begin
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      wr_count++;
      wr_cycles.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e)
          begin
            errors++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     wr_addr, wr_data, e[63:32], e[31:0]);
          end
      end
    end
  end

  // driver tasks (all operate at posedge+1)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    byte_valid = 1'b0;
    step($urandom_range(0, gap));
    byte_valid = 1'b1;
    byte_data  = b;
    waited = 0;
    while (byte_ready !== 1'b1 && waited < 200) begin
      step(1);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_ready=%b, required 1 within 200 cycles", byte_ready);
    end else begin
      step(1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL end_timeout: done=%b error=%b, required one of them high", done, error);
    end
  endtask

  // Reference model: words are little-endian sums of the data bytes; fill covers the rest.
  task automatic run_load(input int n, input int gap, input bit corrupt);
    logic [31:0] w;
    logic [7:0]  cs;
    bit          ok;
    int          s;
`ifdef LOADER_CHECKSUM_EN
    ok = !corrupt;
`else
    ok = 1'b1;
`endif
    exp_q.delete();
    wr_cycles.delete();
    cs = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = 32'(data_b[4*i]) + 32'(data_b[4*i+1]) * 256 + 32'(data_b[4*i+2]) * 65536 +
          32'(data_b[4*i+3]) * 16777216;
      exp_q.push_back({32'(i * 4), w});
    end
    for (int k = 0; k < 4 * n; k++) cs = cs ^ data_b[k];
    if (ok) for (int i = n; i < MEM; i++) exp_q.push_back({32'(i * 4), NOP});
    pulse_start();
    send_byte(8'(n), gap);
    for (int k = 0; k < 4 * n; k++) send_byte(data_b[k], gap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gap);
`endif
    wait_end();
    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d writes outstanding, required 0", exp_q.size());
    end
    checks++;
    if ({done, error, cpu_hold, byte_ready} !== (ok ? 4'b1000 : 4'b0110)) begin
      errors++;
      $display("FAIL end_flags: done/error/hold/ready=%b, required %b",
               {done, error, cpu_hold, byte_ready}, (ok ? 4'b1000 : 4'b0110));
    end
`ifdef LOADER_CHECKSUM_EN
    s = n + 1;
`else
    s = n;
`endif
    if (ok) begin
      for (int i = s; i < wr_cycles.size(); i++) begin
        checks++;
        if (wr_cycles[i] - wr_cycles[i-1] != 1) begin
          errors++;
          $display("FAIL fill_spacing: write %0d came %0d cycles after previous, required 1",
                   i, wr_cycles[i] - wr_cycles[i-1]);
        end
      end
    end
  endtask

  task automatic fill_random(input int n);
    data_b.delete();
    for (int k = 0; k < 4 * n; k++) data_b.push_back(8'($urandom_range(0, 255)));
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({cpu_hold, wr_en, byte_ready, done, error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: hold/wr_en/ready/done/error=%b, required 10000",
               {cpu_hold, wr_en, byte_ready, done, error});
    end
    checks++;
    if ({wr_addr, wr_data} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h, required 0", wr_addr, wr_data);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: byte_ready=%b, required 0", byte_ready);
    end
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: byte_ready=%b, required 1", byte_ready);
    end
    do_reset();
  endtask

  task automatic test_basic();
    data_b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    run_load(2, 0, 1'b0);
  endtask

  task automatic test_gaps();
    fill_random(MEM);
    run_load(MEM, 5, 1'b0);
    run_load(MEM, 0, 1'b0);
  endtask

  task automatic test_random();
    repeat (4) begin
      int n;
      n = $urandom_range(1, MEM);
      fill_random(n);
      run_load(n, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_bad_count();
    int w0;
    exp_q.delete();
    w0 = wr_count;
    pulse_start();
    send_byte(8'd0, 1);
    wait_end();
    step(2);
    checks++;
    if ({error, done, cpu_hold, byte_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL count0_flags: error/done/hold/ready=%b, required 1010",
               {error, done, cpu_hold, byte_ready});
    end
    pulse_start();
    checks++;
    if ({error, cpu_hold} !== 2'b01) begin
      errors++;
      $display("FAIL restart_clear: error/hold=%b, required 01", {error, cpu_hold});
    end
    send_byte(8'(MEM + 1), 1);
    wait_end();
    step(2);
    checks++;
    if ({error, done, cpu_hold} !== 3'b101) begin
      errors++;
      $display("FAIL count7_flags: error/done/hold=%b, required 101", {error, done, cpu_hold});
    end
    checks++;
    if (wr_count != w0) begin
      errors++;
      $display("FAIL error_writes: %0d writes, required 0", wr_count - w0);
    end
    fill_random(1);
    run_load(1, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int w0;
    data_b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93};
    exp_q.delete();
    exp_q.push_back({32'd0, 32'h00500513});
    pulse_start();
    send_byte(8'd2, 0);
    for (int k = 0; k < 5; k++) send_byte(data_b[k], 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({byte_ready, wr_en, cpu_hold, done, error} !== 5'b00100) begin
      errors++;
      $display("FAIL async_reset_flags: ready/wr_en/hold/done/error=%b, required 00100",
               {byte_ready, wr_en, cpu_hold, done, error});
    end
    checks++;
    if ({wr_addr, wr_data} !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_bus: addr=%h data=%h, required 0", wr_addr, wr_data);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_write: %0d writes outstanding, required 0", exp_q.size());
    end
    step(2);
    rst = 1'b0;
    w0 = wr_count;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    step(20);
    byte_valid = 1'b0;
    checks++;
    if (wr_count != w0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: writes=%0d ready=%b, required 0 and 0",
               wr_count - w0, byte_ready);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    data_b = '{8'h13, 8'h05, 8'h50, 8'h00};
    run_load(1, 0, 1'b0);
    run_load(1, 0, 1'b1);
    fill_random(3);
    run_load(3, 2, 1'b0);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_basic();
    test_gaps();
    test_random();
    test_bad_count();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
